// File: rtl/pll_drp_reconfig_seq_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL
// wrapper's DRP port (slave).
//   drp_sel/drp_rd/drp_wr : one-cycle access strobes (master -> slave)
//   drp_addr/drp_wdata    : 8-bit address / write data, held until drp_rdy
//   drp_rdy/drp_err       : access completion and error (slave -> master)
//   drp_rdata             : 8-bit read data, valid with drp_rdy
interface pll_drp_reconfig_seq_if;
  logic       drp_sel;
  logic       drp_rd;
  logic       drp_wr;
  logic [7:0] drp_addr;
  logic [7:0] drp_wdata;
  logic       drp_rdy;
  logic       drp_err;
  logic [7:0] drp_rdata;

  modport master (
    output drp_sel, drp_rd, drp_wr, drp_addr, drp_wdata,
    input  drp_rdy, drp_err, drp_rdata
  );

  modport slave (
    input  drp_sel, drp_rd, drp_wr, drp_addr, drp_wdata,
    output drp_rdy, drp_err, drp_rdata
  );
endinterface

// File: rtl/pll_drp_reconfig_seq.sv
// PLL DRP reconfiguration sequencer.
// Applies one stored profile of {valid, addr, mask, data} entries to the PLL
// through its DRP port as masked read-modify-writes (plain writes when the
// mask is 8'hFF) while holding the PLL in reset, then releases reset and
// waits for lock with timeout and whole-sequence retry.
// Ports:
//   drp_clk, drp_rstn   : clock, asynchronous active-low reset
//   tbl_we/addr/data    : profile table write port (index = profile*ENTRIES+entry)
//   start, profile_sel  : sequence request and profile to apply
//   busy, done, err_code: status (0 OK, 1 DRP timeout, 2 drp_err, 3 lock fail,
//                         4 verify mismatch)
//   pll_rst, pll_lock   : PLL reset output, asynchronous lock input
//   locked              : synchronised lock, only while not busy
//   drp                 : DRP bus (master modport)
// Optional build macro: PLL_RECFG_VERIFY_EN adds a read-back check of every
// written entry (error code 4 on mismatch).
module pll_drp_reconfig_seq #(
  parameter int NUM_PROFILES = 4,
  parameter int ENTRIES      = 8,
  parameter int DRP_TIMEOUT  = 255,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 2,
  localparam int AW = (NUM_PROFILES * ENTRIES > 1) ? $clog2(NUM_PROFILES * ENTRIES) : 1,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          drp_clk,
  input  logic          drp_rstn,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [24:0]   tbl_data,
  input  logic          start,
  input  logic [PW-1:0] profile_sel,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err_code,
  output logic          pll_rst,
  input  logic          pll_lock,
  output logic          locked,
  pll_drp_reconfig_seq_if.master drp
);

  localparam int NE = NUM_PROFILES * ENTRIES;
  localparam int EW = $clog2(ENTRIES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
    S_VF_REQ, S_VF_WAIT, S_HOLD, S_LOCK_WAIT, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [24:0]   tbl [NE];
  logic [PW-1:0] prof;
  logic [EW-1:0] entry;
  logic [RW-1:0] retry;
  logic [31:0]   cnt;
  logic [7:0]    cur_mask;
  logic [7:0]    cur_data;
  logic          lock_meta;
  logic          lock_s;
  logic [AW-1:0] fetch_idx;
  logic [24:0]   fetch_word;
  logic [7:0]    rmw_data;

  // Profile table
  always_ff @(posedge drp_clk or negedge drp_rstn) begin
    if (!drp_rstn) begin
      for (int unsigned i = 0; i < NE; i++) tbl[AW'(i)] <= '0;
    end else if (tbl_we && (32'(tbl_addr) < 32'(NE))) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  assign fetch_idx = AW'(32'(prof) * 32'(ENTRIES) + 32'(entry));

  always_comb begin
    fetch_word = '0;
    if (32'(fetch_idx) < 32'(NE)) fetch_word = tbl[fetch_idx];
  end

  assign rmw_data = (drp.drp_rdata & ~cur_mask) | (cur_data & cur_mask);

  // Lock synchroniser
  always_ff @(posedge drp_clk or negedge drp_rstn) begin
    if (!drp_rstn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign locked = lock_s & ~busy;

  // Sequencer. Strobes are set on the transition into a *_REQ state so they
  // are high for exactly the REQ cycle; drp_rdy is only looked at in *_WAIT.
  always_ff @(posedge drp_clk or negedge drp_rstn) begin
    if (!drp_rstn) begin
      state         <= S_IDLE;
      prof          <= '0;
      entry         <= '0;
      retry         <= '0;
      cnt           <= '0;
      cur_mask      <= '0;
      cur_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_code      <= '0;
      pll_rst       <= 1'b1;
      drp.drp_sel   <= 1'b0;
      drp.drp_rd    <= 1'b0;
      drp.drp_wr    <= 1'b0;
      drp.drp_addr  <= '0;
      drp.drp_wdata <= '0;
    end else begin
      done        <= 1'b0;
      drp.drp_sel <= 1'b0;
      drp.drp_rd  <= 1'b0;
      drp.drp_wr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            prof     <= profile_sel;
            entry    <= '0;
            retry    <= '0;
            err_code <= '0;
            busy     <= 1'b1;
            pll_rst  <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (entry == EW'(ENTRIES) || !fetch_word[24]) begin
            // HOLD counts from the last drp_rdy, two cycles back.
            cnt   <= 32'd2;
            state <= S_HOLD;
          end else begin
            drp.drp_addr <= fetch_word[23:16];
            cur_mask     <= fetch_word[15:8];
            cur_data     <= fetch_word[7:0];
            drp.drp_sel  <= 1'b1;
            if (fetch_word[15:8] == 8'hFF) begin
              drp.drp_wdata <= fetch_word[7:0];
              drp.drp_wr    <= 1'b1;
              state         <= S_WR_REQ;
            end else begin
              drp.drp_rd <= 1'b1;
              state      <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_WR_REQ: begin
          cnt   <= '0;
          state <= S_WR_WAIT;
        end
        S_VF_REQ: begin
          cnt   <= '0;
          state <= S_VF_WAIT;
        end
        S_RD_WAIT, S_WR_WAIT, S_VF_WAIT: begin
          if (drp.drp_rdy) begin
            if (drp.drp_err) begin
              err_code <= 3'd2;
              done     <= 1'b1;
              state    <= S_FAIL;
            end else if (state == S_RD_WAIT) begin
              drp.drp_wdata <= rmw_data;
              drp.drp_sel   <= 1'b1;
              drp.drp_wr    <= 1'b1;
              state         <= S_WR_REQ;
`ifdef PLL_RECFG_VERIFY_EN
            end else if (state == S_WR_WAIT) begin
              drp.drp_sel <= 1'b1;
              drp.drp_rd  <= 1'b1;
              state       <= S_VF_REQ;
            end else if ((drp.drp_rdata & cur_mask) != (cur_data & cur_mask)) begin
              err_code <= 3'd4;
              done     <= 1'b1;
              state    <= S_FAIL;
`endif
            end else begin
              entry <= entry + EW'(1);
              state <= S_FETCH;
            end
          end else if (cnt == 32'(DRP_TIMEOUT - 1)) begin
            err_code <= 3'd1;
            done     <= 1'b1;
            state    <= S_FAIL;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt + 32'd1 >= 32'(RST_HOLD)) begin
            pll_rst <= 1'b0;
            cnt     <= '0;
            state   <= S_LOCK_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_LOCK_WAIT: begin
          if (lock_s) begin
            err_code <= 3'd0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
            pll_rst <= 1'b1;
            if (32'(retry) < 32'(MAX_RETRY)) begin
              retry <= retry + RW'(1);
              entry <= '0;
              state <= S_FETCH;
            end else begin
              err_code <= 3'd3;
              done     <= 1'b1;
              state    <= S_FAIL;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE, S_FAIL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig_seq.sv
// Self-checking bench for pll_drp_reconfig_seq: DRP slave model with a
// scoreboard of expected accesses, a PLL lock model, and one task per scenario.
`timescale 1ns/1ps
module tb_pll_drp_reconfig_seq;
  localparam int P_NP  = 4;
  localparam int P_ENT = 8;
  localparam int P_DT  = 20;
  localparam int P_RH  = 16;
  localparam int P_LT  = 200;
  localparam int P_MR  = 2;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic        drp_clk = 1'b0;
  logic        drp_rstn = 1'b1;
  logic        tbl_we = 1'b0;
  logic [4:0]  tbl_addr = '0;
  logic [24:0] tbl_data = '0;
  logic        start = 1'b0;
  logic [1:0]  profile_sel = '0;
  logic        busy, done, pll_rst, locked;
  logic [2:0]  err_code;
  logic        pll_lock = 1'b0;

  pll_drp_reconfig_seq_if drp ();

  pll_drp_reconfig_seq #(
    .NUM_PROFILES(P_NP), .ENTRIES(P_ENT), .DRP_TIMEOUT(P_DT),
    .RST_HOLD(P_RH), .LOCK_TIMEOUT(P_LT), .MAX_RETRY(P_MR)
  ) dut (
    .drp_clk(drp_clk), .drp_rstn(drp_rstn),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .profile_sel(profile_sel),
    .busy(busy), .done(done), .err_code(err_code),
    .pll_rst(pll_rst), .pll_lock(pll_lock), .locked(locked),
    .drp(drp.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  acc_t exp_q[$];
  logic [7:0] mem [256];
  int rdy_delay = 2;
  bit hang = 0;
  int err_on_write = 0;
  int wr_count = 0;
  logic [7:0] corrupt = '0;
  int pend = 0;
  logic pend_wr = 1'b0;
  logic [7:0] pend_addr = '0;
  logic [7:0] pend_wdata = '0;
  int strobe_cyc = 0;
  int last_rdy_cyc = 0;
  int n_acc = 0;
  int lock_fail_first = 0;
  int attempts = 0;
  int rst_fall_cyc = 0;
  int lock_cnt = 0;
  bit prev_rst = 1;

  initial forever #5 drp_clk = ~drp_clk;
  initial forever begin @(posedge drp_clk); cyc++; end

  // DRP slave model and scoreboard
  initial begin
    acc_t e;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    drp.drp_rdy = 1'b0; drp.drp_err = 1'b0; drp.drp_rdata = '0;
    forever begin
      @(negedge drp_clk);
      drp.drp_rdy = 1'b0;
      drp.drp_err = 1'b0;
      if (!drp_rstn) pend = 0;
      if (pend > 0) begin
        vectors++;
        if (drp.drp_addr !== pend_addr || (pend_wr && drp.drp_wdata !== pend_wdata)) begin
          miscompares++;
          $display("FAIL drp_hold: addr %h wdata %h, required addr %h wdata %h",
                   drp.drp_addr, drp.drp_wdata, pend_addr, pend_wdata);
        end
        pend--;
        if (pend == 0) begin
          drp.drp_rdy = 1'b1;
          last_rdy_cyc = cyc;
          if (pend_wr) begin
            wr_count++;
            if (wr_count == err_on_write) drp.drp_err = 1'b1;
          end else begin
            drp.drp_rdata = mem[pend_addr] ^ corrupt;
          end
        end
      end
      if (drp_rstn && drp.drp_sel === 1'b1) begin
        strobe_cyc = cyc;
        n_acc++;
        pend_wr = drp.drp_wr;
        pend_addr = drp.drp_addr;
        pend_wdata = drp.drp_wdata;
        if (pend_wr) mem[pend_addr] = pend_wdata;
        pend = hang ? 0 : rdy_delay;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL drp_access: unexpected wr=%b addr %h, required no access", drp.drp_wr, drp.drp_addr);
        end else begin
          e = exp_q.pop_front();
          if (drp.drp_wr !== e.wr || drp.drp_rd !== !e.wr || drp.drp_addr !== e.addr ||
              (e.wr && drp.drp_wdata !== e.data)) begin
            miscompares++;
            $display("FAIL drp_access: wr=%b rd=%b addr %h wdata %h, required wr=%b addr %h wdata %h",
                     drp.drp_wr, drp.drp_rd, drp.drp_addr, drp.drp_wdata, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  // PLL lock model: locks 100 cycles after reset release, except on the
  // first lock_fail_first attempts.
  initial forever begin
    @(negedge drp_clk);
    if (pll_rst !== 1'b0) begin
      pll_lock = 1'b0;
      lock_cnt = 0;
    end else begin
      if (prev_rst) begin attempts++; rst_fall_cyc = cyc; end
      lock_cnt++;
      if (lock_cnt >= 100 && attempts > lock_fail_first) pll_lock = 1'b1;
    end
    prev_rst = (pll_rst !== 1'b0);
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic setup();
    hang = 0; rdy_delay = 2; err_on_write = 0; wr_count = 0; corrupt = '0;
    lock_fail_first = 0; attempts = 0; pend = 0;
    exp_q.delete();
  endtask

  task automatic write_entry(input int p, input int e, input bit v,
                             input logic [7:0] a, input logic [7:0] m, input logic [7:0] d);
    @(negedge drp_clk);
    tbl_we = 1'b1; tbl_addr = 5'(p * P_ENT + e); tbl_data = {v, a, m, d};
    @(negedge drp_clk);
    tbl_we = 1'b0;
  endtask

  task automatic expect_acc(input logic wr, input logic [7:0] a, input logic [7:0] d);
    acc_t t;
    t.wr = wr; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    expect_acc(1'b1, a, d);
`ifdef PLL_RECFG_VERIFY_EN
    expect_acc(1'b0, a, 8'h00);
`endif
  endtask

  task automatic load_profile1();
    write_entry(1, 0, 1'b1, 8'h20, 8'hFF, 8'h11);
    write_entry(1, 1, 1'b1, 8'h21, 8'hFF, 8'h22);
    write_entry(1, 2, 1'b1, 8'h22, 8'hFF, 8'h33);
    write_entry(1, 3, 1'b0, 8'h23, 8'hFF, 8'h44);
  endtask

  task automatic expect_profile1();
    expect_write(8'h20, 8'h11);
    expect_write(8'h21, 8'h22);
    expect_write(8'h22, 8'h33);
  endtask

  // Pulses start, checks the 1-cycle pll_rst/busy response, waits for done.
  task automatic run_seq(input int prof, input int max_cyc);
    bit got = 0;
    @(negedge drp_clk);
    profile_sel = 2'(prof); start = 1'b1;
    @(negedge drp_clk);
    start = 1'b0;
    vectors++;
    if (pll_rst !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_resp: pll_rst=%b busy=%b, required 1 1", pll_rst, busy);
    end
    for (int i = 0; i < max_cyc; i++) begin
      if (done === 1'b1) begin got = 1; break; end
      @(negedge drp_clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_wait: no done within %0d cycles, required done", max_cyc);
    end
  endtask

  task automatic test_reset();
    #1 drp_rstn = 1'b0;
    repeat (3) @(negedge drp_clk);
    drp_rstn = 1'b1;
    @(negedge drp_clk);
    vectors++;
    if ({busy, done, err_code, pll_rst, locked} !== 7'b0_0_000_1_0) begin
      miscompares++;
      $display("FAIL reset_status: busy/done/err/pll_rst/locked=%b, required 0000010",
               {busy, done, err_code, pll_rst, locked});
    end
    vectors++;
    if ({drp.drp_sel, drp.drp_rd, drp.drp_wr, drp.drp_addr, drp.drp_wdata} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_drp: sel/rd/wr/addr/wdata=%h, required 0",
               {drp.drp_sel, drp.drp_rd, drp.drp_wr, drp.drp_addr, drp.drp_wdata});
    end
  endtask

  task automatic test_write_only();
    setup();
    load_profile1();
    expect_profile1();
    run_seq(1, 2000);
    vectors++;
    if (err_code !== 3'd0) begin
      miscompares++; $display("FAIL wo_code: got %0d, required 0", err_code);
    end
    vectors++;
    if (wr_count !== 3 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL wo_writes: writes %0d pending %0d, required 3 0", wr_count, exp_q.size());
    end
    vectors++;
    if (rst_fall_cyc - last_rdy_cyc !== P_RH) begin
      miscompares++;
      $display("FAIL wo_hold: pll_rst fell %0d cycles after rdy, required %0d", rst_fall_cyc - last_rdy_cyc, P_RH);
    end
    @(negedge drp_clk);
    vectors++;
    if ({done, busy, locked, pll_rst} !== 4'b0010) begin
      miscompares++;
      $display("FAIL wo_after: done/busy/locked/pll_rst=%b, required 0010", {done, busy, locked, pll_rst});
    end
  endtask

  task automatic test_rmw();
    setup();
    mem[8'h10] = 8'hA5;
    write_entry(2, 0, 1'b1, 8'h10, 8'h0F, 8'h03);
    expect_acc(1'b0, 8'h10, 8'h00);
    expect_write(8'h10, 8'hA3);
    run_seq(2, 2000);
    vectors++;
    if (err_code !== 3'd0 || mem[8'h10] !== 8'hA3 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rmw: code %0d reg %h pending %0d, required 0 a3 0", err_code, mem[8'h10], exp_q.size());
    end
    // start coincident with done must be ignored
    start = 1'b1; profile_sel = 2'd1;
    @(negedge drp_clk);
    start = 1'b0;
    @(negedge drp_clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL start_on_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_drp_timeout();
    setup();
    hang = 1;
    write_entry(3, 0, 1'b1, 8'h30, 8'hFF, 8'h44);
    expect_acc(1'b1, 8'h30, 8'h44);
    run_seq(3, 2000);
    vectors++;
    if (cyc - strobe_cyc !== P_DT + 1) begin
      miscompares++;
      $display("FAIL to_latency: done %0d cycles after strobe, required %0d", cyc - strobe_cyc, P_DT + 1);
    end
    vectors++;
    if (err_code !== 3'd1 || pll_rst !== 1'b1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL to_code: code %0d pll_rst %b pending %0d, required 1 1 0", err_code, pll_rst, exp_q.size());
    end
  endtask

  task automatic test_lock_retry();
    setup();
    lock_fail_first = 2;
    for (int i = 0; i < 3; i++) expect_profile1();
    run_seq(1, 3000);
    vectors++;
    if (err_code !== 3'd0 || attempts !== 3 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL retry_ok: code %0d attempts %0d pending %0d, required 0 3 0", err_code, attempts, exp_q.size());
    end
    setup();
    lock_fail_first = 99;
    for (int i = 0; i < 3; i++) expect_profile1();
    run_seq(1, 3000);
    vectors++;
    if (err_code !== 3'd3 || attempts !== P_MR + 1 || pll_rst !== 1'b1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL retry_fail: code %0d attempts %0d pll_rst %b pending %0d, required 3 %0d 1 0",
               err_code, attempts, pll_rst, exp_q.size(), P_MR + 1);
    end
  endtask

  task automatic test_drp_err();
    int acc_at_done;
    setup();
    err_on_write = 2;
    expect_write(8'h20, 8'h11);
    expect_acc(1'b1, 8'h21, 8'h22);
    run_seq(1, 2000);
    acc_at_done = n_acc;
    vectors++;
    if (err_code !== 3'd2 || pll_rst !== 1'b1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL err_code: code %0d pll_rst %b pending %0d, required 2 1 0", err_code, pll_rst, exp_q.size());
    end
    repeat (10) @(negedge drp_clk);
    vectors++;
    if (n_acc !== acc_at_done) begin
      miscompares++; $display("FAIL err_noaccess: %0d extra accesses, required 0", n_acc - acc_at_done);
    end
  endtask

  task automatic test_async_reset();
    int base;
    setup();
    hang = 1;
    mem[8'h10] = 8'hA5;
    expect_acc(1'b0, 8'h10, 8'h00);
    base = n_acc;
    @(negedge drp_clk);
    profile_sel = 2'd2; start = 1'b1;
    @(negedge drp_clk);
    start = 1'b0;
    for (int i = 0; i < 20 && n_acc == base; i++) @(negedge drp_clk);
    @(negedge drp_clk);
    #2 drp_rstn = 1'b0;
    #1;
    vectors++;
    if ({drp.drp_sel, drp.drp_rd, drp.drp_wr, pll_rst, busy} !== 5'b00010 || n_acc !== base + 1) begin
      miscompares++;
      $display("FAIL async_rst: sel/rd/wr/pll_rst/busy=%b accesses %0d, required 00010 1",
               {drp.drp_sel, drp.drp_rd, drp.drp_wr, pll_rst, busy}, n_acc - base);
    end
    @(negedge drp_clk);
    drp_rstn = 1'b1;
    setup();
    load_profile1();
    expect_profile1();
    run_seq(1, 2000);
    vectors++;
    if (err_code !== 3'd0 || wr_count !== 3 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL post_rst_run: code %0d writes %0d pending %0d, required 0 3 0", err_code, wr_count, exp_q.size());
    end
  endtask

`ifdef PLL_RECFG_VERIFY_EN
  task automatic test_verify();
    setup();
    corrupt = 8'h01;
    write_entry(0, 0, 1'b1, 8'h40, 8'hFF, 8'h55);
    expect_acc(1'b1, 8'h40, 8'h55);
    expect_acc(1'b0, 8'h40, 8'h00);
    run_seq(0, 2000);
    vectors++;
    if (err_code !== 3'd4 || exp_q.size() !== 0) begin
      miscompares++; $display("FAIL verify: code %0d pending %0d, required 4 0", err_code, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_only();
    test_rmw();
    test_drp_timeout();
    test_lock_retry();
    test_drp_err();
    test_async_reset();
`ifdef PLL_RECFG_VERIFY_EN
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
